etapa_mem: RTL and testbench
============================

ETAPA_MEM -- requirements
Module: etapa_mem

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter REGS, default 5, meaning register-index width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 i_PCBranch, i_ALU, i_Registro2  in  NBITS each  branch target, address/ALU result, store data.
REQ-007 i_Cero, i_Branch, i_MemWrite, i_MemRead, i_MemToReg, i_RegWrite, i_SinSigno  in  1 each  EX/MEM flags.
REQ-008 i_TamanoFiltro  in  2  access size: 00 byte, 01 half, 11 word, 10 treated as word.
REQ-009 i_RegistroDestino  in  REGS  destination register.
REQ-010 o_MemReq, o_MemWe  out  1  data-memory request and write enable.
REQ-011 o_MemAddr, o_MemWData  out  NBITS  word-aligned address (bits[1:0]=0) and lane-replicated store data.
REQ-012 o_MemBe  out  4  byte enables.
REQ-013 i_MemAck  in  1, i_MemRData  in  NBITS  memory completion and read word.
REQ-014 o_PCSrc  out  1, o_PCBranch  out  NBITS  branch taken, target.
REQ-015 o_Stall  out  1  hold upstream pipeline.
REQ-016 o_ReadData, o_ALU  out  NBITS; o_RegistroDestino  out  REGS; o_MemToReg, o_RegWrite  out  1  registered MEM/WB outputs.

Function
REQ-017 o_PCSrc SHALL equal i_Branch AND i_Cero combinationally; o_PCBranch = i_PCBranch.
REQ-018 FSM states SHALL be IDLE, ACCESO, HECHO.
REQ-019 IDLE with (i_MemRead|i_MemWrite): o_Stall=1 combinationally, next state ACCESO; otherwise stay IDLE, o_Stall=0.
REQ-020 ACCESO: o_MemReq=1 registered, address/data/enables held stable; o_Stall=1 while i_MemAck=0; i_MemAck=1 captures i_MemRData, next HECHO.
REQ-021 HECHO: o_MemReq=0, o_Stall=0, next IDLE unconditionally.
REQ-022 i_MemAck outside ACCESO SHALL be ignored.
REQ-023 MEM/WB outputs SHALL load on rising edge when o_Stall=0; when o_Stall=1 they SHALL load a bubble (o_RegWrite=0, o_MemToReg=0, data unchanged).
REQ-024 Latency: non-memory instruction 1 cycle; memory instruction 2 cycles plus ack wait cycles.
REQ-025 Byte enables: byte -> one lane by addr[1:0]; half -> 0011 (addr[1]=0) or 1100 (addr[1]=1), addr[0] ignored; word -> 1111.
REQ-026 Loads SHALL extract the selected lane(s) right-justified, sign-extended unless i_SinSigno=1 (zero-extended); word loads unmodified.
REQ-027 Stores SHALL replicate byte to all 4 lanes, half to both halves.
REQ-028 i_MemRead and i_MemWrite both set: write executes, o_MemToReg forced 0, o_ReadData=0.
REQ-029 Non-memory instruction: o_ReadData=0, o_ALU/o_RegistroDestino/o_RegWrite/o_MemToReg pass through.

Reset
REQ-030 Reset SHALL force IDLE, o_MemReq=0, o_MemWe=0, o_MemBe=0, o_MemAddr=0, o_MemWData=0, all MEM/WB outputs 0.
REQ-031 Reset during ACCESO SHALL drop o_MemReq next cycle; a late ack SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, TamanoFiltro codes, and byte-enable constants.
REQ-033 Lane extraction/extension SHALL be sub-module filtro_carga (combinational, instantiated once).

Verification
REQ-034 ALU=0x1003, LB, i_SinSigno=0, RData=0x80FF_FF7F, ack after 2 waits -> o_MemBe=1000, o_ReadData=0xFFFF_FF80, o_Stall high 3 cycles.
REQ-035 ALU=0x1002, SH, Registro2=0x0000_ABCD, immediate ack -> o_MemBe=1100, o_MemWData=0xABCD_ABCD, o_MemWe=1, o_RegWrite=0.
REQ-036 ADD result 0x55, RegWrite=1, no mem -> o_Stall=0, next cycle o_ALU=0x55, o_RegWrite=1.
REQ-037 Branch=1, Cero=1, PCBranch=0x40 -> o_PCSrc=1, o_PCBranch=0x40 same cycle; Cero=0 -> o_PCSrc=0.
REQ-038 Reset asserted in ACCESO, ack arrives one cycle later -> IDLE, o_MemReq=0, no write-back.
REQ-039 i_MemRead=i_MemWrite=1 -> write performed, o_MemToReg=0, o_ReadData=0.

Source files
------------

// File: rtl/etapa_mem_pkg.sv
// etapa_mem_pkg: shared FSM states, access-size codes and byte-enable constants for the MEM stage.
package etapa_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESO, HECHO} estado_t;
    typedef enum logic [1:0] {
        TAM_BYTE = 2'b00,
        TAM_HALF = 2'b01,
        TAM_ANCHO = 2'b10,
        TAM_WORD = 2'b11
    } tam_t;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;
    // Code 10 falls through to a full word.
    function automatic logic [3:0] be_de(input logic [1:0] tam, input logic [1:0] lo);
        return tam == TAM_BYTE ? BE_BYTE << lo : tam == TAM_HALF ? (lo[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
    endfunction
endpackage

// File: rtl/filtro_carga.sv
// filtro_carga: picks the addressed byte/half of a read word, right-justifies and extends it.
module filtro_carga
    import etapa_mem_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] datos,
    input  logic [1:0]       lo,
    input  logic [1:0]       tam,
    input  logic             sin_signo,
    output logic [NBITS-1:0] cargado
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = datos[8*lo +: 8];
        h = lo[1] ? datos[16 +: 16] : datos[0 +: 16];
        cargado = tam == TAM_BYTE ? {{(NBITS-8){b[7] & ~sin_signo}}, b}
                : tam == TAM_HALF ? {{(NBITS-16){h[15] & ~sin_signo}}, h}
                : datos;
    end
endmodule

// File: rtl/etapa_mem.sv
// etapa_mem: pipeline MEM stage with a stalling data-memory handshake and MEM/WB register.
module etapa_mem
    import etapa_mem_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int REGS = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NBITS-1:0] i_PCBranch,
    input  logic [NBITS-1:0] i_ALU,
    input  logic [NBITS-1:0] i_Registro2,
    input  logic             i_Cero,
    input  logic             i_Branch,
    input  logic             i_MemWrite,
    input  logic             i_MemRead,
    input  logic             i_MemToReg,
    input  logic             i_RegWrite,
    input  logic             i_SinSigno,
    input  logic [1:0]       i_TamanoFiltro,
    input  logic [REGS-1:0]  i_RegistroDestino,
    output logic             o_MemReq,
    output logic             o_MemWe,
    output logic [NBITS-1:0] o_MemAddr,
    output logic [NBITS-1:0] o_MemWData,
    output logic [3:0]       o_MemBe,
    input  logic             i_MemAck,
    input  logic [NBITS-1:0] i_MemRData,
    output logic             o_PCSrc,
    output logic [NBITS-1:0] o_PCBranch,
    output logic             o_Stall,
    output logic [NBITS-1:0] o_ReadData,
    output logic [NBITS-1:0] o_ALU,
    output logic [REGS-1:0]  o_RegistroDestino,
    output logic             o_MemToReg,
    output logic             o_RegWrite
);
    estado_t          estado;
    logic [1:0]       lo, tam;
    logic             acceso_mem, ack;
    logic [NBITS-1:0] cargado, wdata;

    assign acceso_mem = i_MemRead | i_MemWrite;
    assign ack = estado == ACCESO && i_MemAck;
    assign o_PCSrc = i_Branch & i_Cero;
    assign o_PCBranch = i_PCBranch;

    always_comb begin
        o_Stall = estado == IDLE ? acceso_mem : estado == ACCESO ? ~i_MemAck : 1'b0;
        wdata = i_TamanoFiltro == TAM_BYTE ? {(NBITS/8){i_Registro2[7:0]}}
              : i_TamanoFiltro == TAM_HALF ? {(NBITS/16){i_Registro2[15:0]}}
              : i_Registro2;
    end

    filtro_carga #(.NBITS(NBITS)) u_filtro (
        .datos(i_MemRData),
        .lo(lo),
        .tam(tam),
        .sin_signo(i_SinSigno),
        .cargado(cargado)
    );

    // HECHO is a one-cycle turnaround: upstream has already advanced, so only a non-memory op may arrive here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            estado <= IDLE;
            o_MemReq <= 1'b0;
            o_MemWe <= 1'b0;
            o_MemAddr <= '0;
            o_MemWData <= '0;
            o_MemBe <= '0;
            lo <= '0;
            tam <= '0;
            o_ReadData <= '0;
            o_ALU <= '0;
            o_RegistroDestino <= '0;
            o_MemToReg <= 1'b0;
            o_RegWrite <= 1'b0;
        end else begin
            case (estado)
                IDLE: if (acceso_mem) begin
                    estado <= ACCESO;
                    o_MemReq <= 1'b1;
                    o_MemWe <= i_MemWrite;
                    o_MemAddr <= {i_ALU[NBITS-1:2], 2'b00};
                    o_MemWData <= wdata;
                    o_MemBe <= be_de(i_TamanoFiltro, i_ALU[1:0]);
                    lo <= i_ALU[1:0];
                    tam <= i_TamanoFiltro;
                end
                ACCESO: if (i_MemAck) begin
                    estado <= HECHO;
                    o_MemReq <= 1'b0;
                    o_MemWe <= 1'b0;
                end
                default: estado <= IDLE;
            endcase
            o_RegWrite <= ~o_Stall & i_RegWrite;
            o_MemToReg <= ~o_Stall & i_MemToReg & ~i_MemWrite;
            if (!o_Stall) begin
                o_ALU <= i_ALU;
                o_RegistroDestino <= i_RegistroDestino;
                o_ReadData <= (ack && !o_MemWe) ? cargado : '0;
            end
        end
    end
endmodule

// File: tb/tb_etapa_mem.sv
// tb_etapa_mem: randomized MEM-stage bench with a write-back scoreboard and arithmetic reference model.
module tb_etapa_mem;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [31:0] i_PCBranch = '0, i_ALU = '0, i_Registro2 = '0, i_MemRData = '0;
    logic        i_Cero = 0, i_Branch = 0, i_MemWrite = 0, i_MemRead = 0, i_MemToReg = 0;
    logic        i_RegWrite = 0, i_SinSigno = 0, i_MemAck = 0;
    logic [1:0]  i_TamanoFiltro = '0;
    logic [4:0]  i_RegistroDestino = '0;
    logic        o_MemReq, o_MemWe, o_PCSrc, o_Stall, o_MemToReg, o_RegWrite;
    logic [31:0] o_MemAddr, o_MemWData, o_PCBranch, o_ReadData, o_ALU;
    logic [3:0]  o_MemBe;
    logic [4:0]  o_RegistroDestino;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  dst;
        logic        rw;
        logic        m2r;
    } wb_t;
    wb_t exp_q[$];
    int total = 0, bad = 0;

    etapa_mem #(.NBITS(32), .REGS(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_PCBranch(i_PCBranch), .i_ALU(i_ALU),
        .i_Registro2(i_Registro2), .i_Cero(i_Cero), .i_Branch(i_Branch),
        .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead), .i_MemToReg(i_MemToReg),
        .i_RegWrite(i_RegWrite), .i_SinSigno(i_SinSigno), .i_TamanoFiltro(i_TamanoFiltro),
        .i_RegistroDestino(i_RegistroDestino), .o_MemReq(o_MemReq), .o_MemWe(o_MemWe),
        .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData), .o_MemBe(o_MemBe),
        .i_MemAck(i_MemAck), .i_MemRData(i_MemRData), .o_PCSrc(o_PCSrc),
        .o_PCBranch(o_PCBranch), .o_Stall(o_Stall), .o_ReadData(o_ReadData), .o_ALU(o_ALU),
        .o_RegistroDestino(o_RegistroDestino), .o_MemToReg(o_MemToReg), .o_RegWrite(o_RegWrite)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: each edge that was not stalled or reset loads the next scoreboard entry.
    initial begin
        logic p_stall, p_rst;
        wb_t e;
        p_stall = 1'b0;
        p_rst = 1'b1;
        forever begin
            @(negedge i_clk);
            if (!p_rst) begin
                if (!p_stall) begin
                    if (exp_q.size() == 0) chk("wb_unexpected_load", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wb_alu", o_ALU, e.alu);
                        chk("wb_readdata", o_ReadData, e.rdata);
                        chk("wb_dst", {27'd0, o_RegistroDestino}, {27'd0, e.dst});
                        chk("wb_regwrite", {31'd0, o_RegWrite}, {31'd0, e.rw});
                        chk("wb_memtoreg", {31'd0, o_MemToReg}, {31'd0, e.m2r});
                    end
                end else chk("wb_bubble", {30'd0, o_RegWrite, o_MemToReg}, 32'd0);
            end
            p_stall = o_Stall;
            p_rst = i_reset;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Starts at posedge+2, returns at posedge+2 of the cycle in which the next op may be presented.
    task automatic instr(input bit rd, input bit wr, input logic [1:0] tam, input logic [31:0] alu,
                         input logic [31:0] r2, input bit sin, input bit m2r, input bit rw,
                         input logic [4:0] dst, input logic [31:0] rdata, input int waits);
        logic [31:0] wexp, lexp, v;
        logic [3:0]  be;
        int          off, stalls;
        wb_t         e;
        bit          br, ce;
        off = int'(alu % 4);
        case (tam)
            2'b00: begin
                be = 4'b0001 << off;
                wexp = r2[7:0] * 32'h0101_0101;
                v = (rdata >> (8 * off)) & 32'hFF;
                lexp = (!sin && v[7]) ? v | 32'hFFFF_FF00 : v;
            end
            2'b01: begin
                be = off >= 2 ? 4'b1100 : 4'b0011;
                wexp = r2[15:0] * 32'h0001_0001;
                v = (rdata >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
                lexp = (!sin && v[15]) ? v | 32'hFFFF_0000 : v;
            end
            default: begin
                be = 4'b1111;
                wexp = r2;
                lexp = rdata;
            end
        endcase
        br = 1'($urandom);
        ce = 1'($urandom);
        {i_MemRead, i_MemWrite, i_TamanoFiltro, i_ALU, i_Registro2} = {rd, wr, tam, alu, r2};
        {i_SinSigno, i_MemToReg, i_RegWrite, i_RegistroDestino} = {sin, m2r, rw, dst};
        {i_Branch, i_Cero, i_PCBranch, i_MemAck, i_MemRData} = {br, ce, $urandom, 1'($urandom), $urandom};
        e.alu = alu;
        e.rdata = (rd && !wr) ? lexp : 32'd0;
        e.dst = dst;
        e.rw = rw;
        e.m2r = m2r && !wr;
        exp_q.push_back(e);
        #1;
        chk("pcsrc", {31'd0, o_PCSrc}, {31'd0, br & ce});
        chk("pcbranch", o_PCBranch, i_PCBranch);
        chk("stall_first", {31'd0, o_Stall}, {31'd0, rd | wr});
        stalls = int'(o_Stall);
        @(posedge i_clk);
        #2;
        if (!(rd || wr)) return;
        i_MemAck = 1'b0;
        #1;
        chk("mem_req", {31'd0, o_MemReq}, 32'd1);
        chk("mem_we", {31'd0, o_MemWe}, {31'd0, wr});
        chk("mem_addr", o_MemAddr, alu & 32'hFFFF_FFFC);
        chk("mem_be", {28'd0, o_MemBe}, {28'd0, be});
        chk("mem_wdata", o_MemWData, wexp);
        for (int k = 0; k < waits; k++) begin
            stalls += int'(o_Stall);
            @(posedge i_clk);
            #3;
        end
        i_MemAck = 1'b1;
        i_MemRData = rdata;
        #1;
        stalls += int'(o_Stall);
        chk("stall_cycles", stalls, waits + 1);
        @(posedge i_clk);
        #2;
        chk("hecho_req", {31'd0, o_MemReq}, 32'd0);
        chk("hecho_stall", {31'd0, o_Stall}, 32'd0);
    endtask

    initial begin
        bit last_mem, mem, rd, wr;
        wb_t e;
        {i_Branch, i_Cero, i_PCBranch} = {1'b1, 1'b1, 32'h40};
        #1;
        chk("br_taken", {31'd0, o_PCSrc}, 32'd1);
        chk("br_target", o_PCBranch, 32'h40);
        i_Cero = 1'b0;
        #1;
        chk("br_not_taken", {31'd0, o_PCSrc}, 32'd0);
        repeat (2) @(posedge i_clk);
        #3;
        chk("rst_mem_ctl", {26'd0, o_MemReq, o_MemWe, o_MemBe}, 32'd0);
        chk("rst_mem_addr", o_MemAddr, 32'd0);
        chk("rst_mem_wdata", o_MemWData, 32'd0);
        chk("rst_wb", {o_ReadData | o_ALU, o_RegistroDestino, o_MemToReg, o_RegWrite}, 39'd0);
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        instr(1, 0, 2'b00, 32'h1003, 32'h0, 0, 1, 1, 5'd5, 32'h80FF_FF7F, 2);
        instr(0, 0, 2'b11, 32'h7, 32'h0, 0, 0, 1, 5'd1, 32'h0, 0);
        instr(0, 1, 2'b01, 32'h1002, 32'h0000_ABCD, 0, 0, 0, 5'd0, 32'h0, 0);
        instr(0, 0, 2'b11, 32'h55, 32'h0, 0, 0, 1, 5'd9, 32'h0, 0);
        instr(1, 1, 2'b11, 32'h2000, 32'h1234_5678, 0, 1, 1, 5'd7, 32'hDEAD_BEEF, 1);
        instr(0, 0, 2'b11, 32'h8, 32'h0, 0, 0, 0, 5'd2, 32'h0, 0);
        // Reset while the access is outstanding, then a late ack that must be ignored.
        {i_MemRead, i_MemWrite, i_ALU, i_RegWrite, i_MemToReg, i_MemAck} = {1'b1, 1'b0, 32'h3000, 1'b1, 1'b1, 1'b0};
        @(posedge i_clk);
        #3;
        chk("rst_acc_req_before", {31'd0, o_MemReq}, 32'd1);
        #1;
        {i_reset, i_MemRead, i_RegWrite, i_MemToReg} = 4'b1000;
        @(posedge i_clk);
        #2;
        {i_reset, i_MemAck, i_ALU, i_RegWrite, i_RegistroDestino} = {1'b0, 1'b1, 32'h77, 1'b1, 5'd3};
        e.alu = 32'h77;
        e.rdata = 32'd0;
        e.dst = 5'd3;
        e.rw = 1'b1;
        e.m2r = 1'b0;
        exp_q.push_back(e);
        #1;
        chk("rst_acc_req_drop", {31'd0, o_MemReq}, 32'd0);
        chk("rst_acc_no_wb", {31'd0, o_RegWrite}, 32'd0);
        chk("rst_acc_stall", {31'd0, o_Stall}, 32'd0);
        @(posedge i_clk);
        #2;
        chk("rst_acc_idle", {31'd0, o_MemReq}, 32'd0);
        last_mem = 1'b0;
        for (int n = 0; n < 250; n++) begin
            mem = !last_mem && 1'($urandom);
            rd = 1'($urandom);
            wr = !rd || ($urandom_range(0, 3) == 0);
            if (!mem) {rd, wr} = 2'b00;
            instr(rd, wr, 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom), $urandom, $urandom_range(0, 3));
            last_mem = mem;
        end
        #5;
        chk("queue_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
